// File: rtl/mmss_pkg.sv
// rtl/mmss_pkg.sv - shared constants for the mm:ss BCD up-counter
package mmss_pkg;

  // Digit geometry and per-digit moduli
  localparam int DIGIT_W   = 4;
  localparam int TENS_MOD  = 6;
  localparam int UNITS_MOD = 10;

  // Packed count values of interest
  localparam logic [15:0] MMSS_MAX  = 16'h5959;
  localparam logic [15:0] MMSS_ZERO = 16'h0000;

  // Digit positions inside the packed count, least significant first
  localparam int SEC_U = 0;
  localparam int SEC_T = 1;
  localparam int MIN_U = 2;
  localparam int MIN_T = 3;

endpackage

// File: rtl/bcd_digit_up.sv
// rtl/bcd_digit_up.sv - one modulo-MOD BCD up-counting digit with load and carry
module bcd_digit_up #(
  parameter int DIGIT_W = 4,
  parameter int MOD     = 10
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic               loadn,
  input  logic               ci,
  input  logic [DIGIT_W-1:0] d_in,
  output logic [DIGIT_W-1:0] q,
  output logic               co
);

  localparam logic [DIGIT_W-1:0] LAST = DIGIT_W'(MOD - 1);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;

  // Digit register; clrn clears it at once, independent of the clock
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Next value: load (out-of-range digits become 0) beats increment, else hold
  always_comb begin
    q_d = q_q;
    if (!loadn) begin
      q_d = (d_in <= LAST) ? d_in : '0;
    end else if (ci) begin
      q_d = (q_q == LAST) ? '0 : q_q + 1'b1;
    end
  end

  assign q  = q_q;
  assign co = ci & (q_q == LAST);

endmodule

// File: rtl/mmss_up_counter.sv
// rtl/mmss_up_counter.sv - mm:ss BCD up-counter top; MMSS_SATURATE_EN holds at 59:59 instead of wrapping
module mmss_up_counter
  import mmss_pkg::*;
(
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 loadn,
  input  logic                 en,
  input  logic [4*DIGIT_W-1:0] CNT_in,
  output logic [4*DIGIT_W-1:0] CNT,
  output logic                 tc,
  output logic                 max,
  output logic                 zero
);

  logic [4*DIGIT_W-1:0] cnt;
  logic [4:0]           carry;
  logic                 at_max;

  assign at_max = (cnt == MMSS_MAX);

`ifdef MMSS_SATURATE_EN
  // At 59:59 the chain is starved of its carry so every digit holds
  assign carry[SEC_U] = en & ~at_max;
`else
  assign carry[SEC_U] = en;
`endif

  bcd_digit_up #(.DIGIT_W(DIGIT_W), .MOD(UNITS_MOD)) u_sec_u (
    .clk   (clk),
    .clrn  (clrn),
    .loadn (loadn),
    .ci    (carry[SEC_U]),
    .d_in  (CNT_in[SEC_U*DIGIT_W +: DIGIT_W]),
    .q     (cnt[SEC_U*DIGIT_W +: DIGIT_W]),
    .co    (carry[SEC_U+1])
  );

  bcd_digit_up #(.DIGIT_W(DIGIT_W), .MOD(TENS_MOD)) u_sec_t (
    .clk   (clk),
    .clrn  (clrn),
    .loadn (loadn),
    .ci    (carry[SEC_T]),
    .d_in  (CNT_in[SEC_T*DIGIT_W +: DIGIT_W]),
    .q     (cnt[SEC_T*DIGIT_W +: DIGIT_W]),
    .co    (carry[SEC_T+1])
  );

  bcd_digit_up #(.DIGIT_W(DIGIT_W), .MOD(UNITS_MOD)) u_min_u (
    .clk   (clk),
    .clrn  (clrn),
    .loadn (loadn),
    .ci    (carry[MIN_U]),
    .d_in  (CNT_in[MIN_U*DIGIT_W +: DIGIT_W]),
    .q     (cnt[MIN_U*DIGIT_W +: DIGIT_W]),
    .co    (carry[MIN_U+1])
  );

  bcd_digit_up #(.DIGIT_W(DIGIT_W), .MOD(TENS_MOD)) u_min_t (
    .clk   (clk),
    .clrn  (clrn),
    .loadn (loadn),
    .ci    (carry[MIN_T]),
    .d_in  (CNT_in[MIN_T*DIGIT_W +: DIGIT_W]),
    .q     (cnt[MIN_T*DIGIT_W +: DIGIT_W]),
    .co    (carry[MIN_T+1])
  );

  // Flags decoded straight from the registered count; the chain carry-out
  // already equals max&en in wrap mode and is zero in saturate mode
  always_comb begin
    CNT  = cnt;
    max  = at_max;
    zero = (cnt == MMSS_ZERO);
    tc   = (at_max & en) | carry[MIN_T+1];
  end

endmodule

// File: tb/tb_mmss_up_counter.sv
// tb/tb_mmss_up_counter.sv - randomized self-checking bench for mmss_up_counter
module tb_mmss_up_counter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        loadn;
  logic        en;
  logic [15:0] CNT_in;
  logic [15:0] CNT;
  logic        tc;
  logic        max;
  logic        zero;

  int total = 0;
  int bad   = 0;
  int secs  = 0;

  mmss_up_counter dut (
    .clk    (clk),
    .clrn   (clrn),
    .loadn  (loadn),
    .en     (en),
    .CNT_in (CNT_in),
    .CNT    (CNT),
    .tc     (tc),
    .max    (max),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  function automatic int decode(input logic [15:0] v);
    int mt, mu, st, su;
    mt = int'(v[15:12]);
    mu = int'(v[11:8]);
    st = int'(v[7:4]);
    su = int'(v[3:0]);
    if (mt > 5) mt = 0;
    if (mu > 9) mu = 0;
    if (st > 5) st = 0;
    if (su > 9) su = 0;
    return mt * 600 + mu * 60 + st * 10 + su;
  endfunction

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    r[15:12] = 4'(s / 600);
    r[11:8]  = 4'((s / 60) % 10);
    r[7:4]   = 4'((s % 60) / 10);
    r[3:0]   = 4'(s % 10);
    return r;
  endfunction

  task automatic check(input string tag);
    logic [15:0] exp_cnt;
    logic        exp_max, exp_zero, exp_tc;
    exp_cnt  = to_bcd(secs);
    exp_max  = (secs == 3599);
    exp_zero = (secs == 0);
    exp_tc   = exp_max & en;
    total++;
    assert (CNT === exp_cnt) else begin
      bad++;
      $error("FAIL %s cnt observed=%h expected=%h", tag, CNT, exp_cnt);
    end
    total++;
    assert (max === exp_max) else begin
      bad++;
      $error("FAIL %s max observed=%b expected=%b", tag, max, exp_max);
    end
    total++;
    assert (zero === exp_zero) else begin
      bad++;
      $error("FAIL %s zero observed=%b expected=%b", tag, zero, exp_zero);
    end
    total++;
    assert (tc === exp_tc) else begin
      bad++;
      $error("FAIL %s tc observed=%b expected=%b", tag, tc, exp_tc);
    end
  endtask

  // One rising edge: advance the reference model from the held inputs, then check
  task automatic step(input string tag);
    @(posedge clk);
    if (!loadn) begin
      secs = decode(CNT_in);
    end else if (en) begin
`ifdef MMSS_SATURATE_EN
      if (secs != 3599) secs = secs + 1;
`else
      secs = (secs + 1) % 3600;
`endif
    end
    #1;
    check(tag);
  endtask

  task automatic load(input logic [15:0] v);
    CNT_in = v;
    loadn  = 1'b0;
    en     = 1'b0;
    step("load");
    loadn  = 1'b1;
  endtask

  initial begin
    clrn   = 1'b1;
    loadn  = 1'b1;
    en     = 1'b0;
    CNT_in = 16'h0000;

    // Reset asserted mid-cycle takes effect before any clock edge
    #3 clrn = 1'b0;
    secs = 0;
    #1 check("reset_async");
    #3 clrn = 1'b1;
    step("idle0");
    step("idle1");

    // Plain counting across seconds and minutes boundaries
    load(16'h0557);
    en = 1'b1;
    step("cnt_0558");
    step("cnt_0559");
    step("cnt_0600");

    // Top of range: wrap (or saturate)
    load(16'h5958);
    en = 1'b1;
    step("to_5959");
    step("past_5959");
    step("past_5959_b");
    en = 1'b0;
    step("en_off");

    // Out-of-range digits load as zero
    load(16'h7A3C);
    step("invalid_hold");

    // Load beats enable
    load(16'h0100);
    CNT_in = 16'h1234;
    loadn  = 1'b0;
    en     = 1'b1;
    step("load_over_en");
    loadn  = 1'b1;
    step("after_load");

    // Asynchronous reset between edges while counting
    load(16'h0009);
    en = 1'b1;
    step("cnt_0010");
    #3 clrn = 1'b0;
    secs = 0;
    #1 check("reset_midcount");
    #2 clrn = 1'b1;
    step("post_reset");

    // Randomized loads and enable patterns, with frequent near-wrap loads
    for (int i = 0; i < 400; i++) begin
      loadn = ($urandom_range(0, 11) == 0) ? 1'b0 : 1'b1;
      en    = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        CNT_in = 16'($urandom);
      end else begin
        CNT_in = 16'h5950 | 16'($urandom_range(0, 9));
      end
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
